// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default parameter values for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_F = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts data grants that bypassed a waiting fetch; asserts force_f_o once the
// fetch port has been passed over STARVE_LIMIT times in a row.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic f_req_i,
  input  logic d_grant_i,
  input  logic f_grant_i,
  output logic force_f_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (f_grant_i) begin
      cnt_d = '0;
    end else if (d_grant_i && f_req_i && (cnt_q != LIMIT)) begin
      // Saturate so the forced fetch stays pending until it is actually granted.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_f_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and MEM-stage data ports onto one memory port.
// Define ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_done,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                stall_f,
  output logic                stall_d,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  f_done_q, f_done_d;
  logic                  d_done_q, d_done_d;
  logic [DATA_W-1:0]     f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
  logic                  grant_f, grant_d;
  logic                  force_f;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .f_req_i  (f_req),
    .d_grant_i(grant_d),
    .f_grant_i(grant_f),
    .force_f_o(force_f)
  );
`else
  assign force_f = 1'b0;
`endif

  // Grants only from IDLE, and never in a done cycle, which gives the one-cycle gap.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if ((state_q == IDLE) && !f_done_q && !d_done_q) begin
      grant_f = f_req && (!d_req || force_f);
      grant_d = d_req && !grant_f;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_f) begin
          state_d     = BUSY_F;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = f_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end
      BUSY_F: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          f_done_d  = 1'b1;
          f_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_f   = f_req && !f_done_q;
  assign stall_d   = d_req && !d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level arbitration model plus a
// randomised memory responder and requesters.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_done;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [BW-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          stall_f, stall_d;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_f(stall_f), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [BW-1:0] be; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mreq_t;
  typedef struct { int port; logic we; logic [DW-1:0] rdata; } done_t;

  mreq_t mem_exp[$];
  done_t done_exp[$];
  int    n_tests = 0;
  int    n_fail = 0;

  // model state: port 1 = data, 2 = fetch
  int    m_busy = 0, m_gap = 0, m_starve = 0, m_done = 0;
  logic  m_we = 1'b0;

  // responder controls
  int            ack_delay = 0;
  bit            noise_en = 1'b0, resp_en = 1'b1, log_en = 1'b0;
  int            glog[$];
  logic [DW-1:0] last_ack_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: one owner at a time, data first, fetch forced after LIMIT bypasses.
  initial forever begin
    @(posedge clk);
    m_done = 0;
    if (reset) begin
      m_busy = 0; m_gap = 0; m_starve = 0;
      mem_exp.delete(); done_exp.delete();
    end else if (m_busy != 0) begin
      if (mem_ack) begin
        done_exp.push_back('{port: m_busy, we: m_we, rdata: mem_rdata});
        m_done = m_busy; m_busy = 0; m_gap = 1;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (f_req && (!d_req || (GUARD && m_starve >= LIMIT))) begin
      m_busy = 2; m_starve = 0; m_we = 1'b0;
      mem_exp.push_back('{we: 1'b0, be: '0, addr: f_addr, wdata: '0});
    end else if (d_req) begin
      m_busy = 1; m_we = d_we;
      if (GUARD && f_req && m_starve < LIMIT) m_starve++;
      mem_exp.push_back('{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata});
    end
  end

  // Memory responder: checks each new request against the scoreboard and acks it.
  initial begin : responder
    mreq_t         e;
    bit            outst;
    int            wait_cnt;
    logic [AW-1:0] held_addr;
    outst = 1'b0; wait_cnt = 0; held_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        outst = 1'b0; mem_ack = 1'b0;
      end else if (resp_en) begin
        if (outst) begin
          chk("mem_req_held", mem_req, 1);
          chk("mem_addr_held", mem_addr, held_addr);
        end else if (mem_req) begin
          chk("grant_pending", mem_exp.size(), 1);
          if (mem_exp.size() > 0) begin
            e = mem_exp.pop_front();
            chk("mem_we", mem_we, e.we);
            chk("mem_be", mem_be, e.be);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
          end
          if (log_en) glog.push_back(int'(mem_we));
          held_addr = mem_addr; outst = 1'b1;
          wait_cnt = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (outst) begin
          mem_rdata = $urandom;
          if (wait_cnt == 0) begin
            mem_ack = 1'b1; last_ack_rdata = mem_rdata; outst = 1'b0;
          end else begin
            mem_ack = 1'b0; wait_cnt--;
          end
        end else begin
          mem_rdata = $urandom;
          mem_ack = noise_en && ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Completion and stall monitor.
  initial begin : done_mon
    done_t e;
    forever begin
      @(negedge clk);
      chk("stall_f", stall_f, f_req && (m_done != 2));
      chk("stall_d", stall_d, d_req && (m_done != 1));
      chk("f_done", f_done, m_done == 2);
      chk("d_done", d_done, m_done == 1);
      if ((f_done || d_done) && done_exp.size() > 0) begin
        e = done_exp.pop_front();
        if (f_done) chk("f_rdata", f_rdata, e.rdata);
        else if (!e.we) chk("d_rdata", d_rdata, e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fetch_drv(input int n);
    int cnt;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      f_req = 1'b1; f_addr = $urandom;
      cnt = 0;
      do begin
        tick(); cnt++;
        if (!f_done) f_addr = $urandom;
      end while (!f_done && cnt < 100);
      chk("f_wait_bound", cnt < 100, 1);
      f_req = 1'b0;
    end
  endtask

  task automatic data_drv(input int n);
    int cnt;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) tick();
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = BW'($urandom);
      d_addr = $urandom; d_wdata = $urandom;
      cnt = 0;
      do begin
        tick(); cnt++;
        if (!d_done) begin d_addr = $urandom; d_wdata = $urandom; end
      end while (!d_done && cnt < 100);
      chk("d_wait_bound", cnt < 100, 1);
      d_req = 1'b0;
    end
  endtask

  initial begin
    int pulses, cnt;
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    #1 reset = 1'b0;
    tick();

    // single fetch, ack in first request cycle
    ack_delay = 0;
    f_req = 1'b1; f_addr = 32'h100;
    tick();
    chk("f1_mem_req", mem_req, 1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_we", mem_we, 0);
    tick();
    chk("f1_done", f_done, 1);
    chk("f1_rdata", f_rdata, last_ack_rdata);
    f_req = 1'b0;
    repeat (2) tick();

    // simultaneous store and fetch: data first, fetch after the gap
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    f_req = 1'b1; f_addr = 32'h140;
    tick();
    chk("s_d_grant_we", mem_we, 1);
    chk("s_d_grant_addr", mem_addr, 32'h2000);
    tick();
    chk("s_d_done", d_done, 1);
    d_req = 1'b0;
    tick();
    chk("s_gap_req", mem_req, 0);
    tick();
    chk("s_f_grant_req", mem_req, 1);
    chk("s_f_grant_we", mem_we, 0);
    chk("s_f_grant_addr", mem_addr, 32'h140);
    tick();
    chk("s_f_done", f_done, 1);
    f_req = 1'b0;
    repeat (2) tick();

    // slow memory: 3 waiting cycles, one done pulse
    ack_delay = 3;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h3; d_addr = 32'h3000;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_done) begin pulses++; d_req = 1'b0; end
    end
    chk("slow_done_pulses", pulses, 1);

    // reset during BUSY_D abandons the access; a late ack is ignored
    ack_delay = 20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3100;
    tick();
    chk("r_grant", mem_req, 1);
    tick();
    #1 reset = 1'b1; d_req = 1'b0;
    #1 chk("r_mem_req_drop", mem_req, 0);
    chk("r_mem_addr_clr", mem_addr, 0);
    chk("r_no_done", d_done, 0);
    tick();
    #1 reset = 1'b0; resp_en = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("r_late_ack_done", d_done, 0);
      chk("r_late_ack_req", mem_req, 0);
      tick();
    end
    resp_en = 1'b1;

    // randomised concurrent traffic with random ack latency and idle-ack noise
    ack_delay = -1; noise_en = 1'b1;
    fork
      fetch_drv(40);
      data_drv(40);
    join
    noise_en = 1'b0;
    repeat (4) tick();

    // both requests held: observe the grant order
    reset = 1'b1; tick(); #1 reset = 1'b0;
    glog.delete(); log_en = 1'b1; ack_delay = 0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h4000; d_wdata = 32'h12345678;
    f_req = 1'b1; f_addr = 32'h500;
    cnt = 0;
    while (glog.size() < 10 && cnt < 300) begin tick(); cnt++; end
    chk("starve_bound", glog.size() >= 10, 1);
    log_en = 1'b0; d_req = 1'b0; f_req = 1'b0;
    for (int i = 0; i < 10 && i < glog.size(); i++)
      chk($sformatf("grant_order_%0d", i), glog[i], (GUARD && (i % 5 == 4)) ? 0 : 1);
    repeat (6) tick();

    chk("mem_exp_empty", mem_exp.size(), 0);
    chk("done_exp_empty", done_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
